// File: rtl/seq_add_pkg.sv
// rtl/seq_add_pkg.sv - shared state encoding and sizing helpers for the sliced adder sequencer
package seq_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Number of slice cycles needed for a w-bit operation on n-bit slices.
    function automatic int slice_count(input int w, input int n);
        return w / n;
    endfunction

    // Counter width that can hold slices-1, never narrower than one bit.
    function automatic int count_width(input int slices);
        return (slices <= 2) ? 1 : $clog2(slices);
    endfunction

endpackage

// File: rtl/add_slice.sv
// rtl/add_slice.sv - combinational N-bit ripple-carry adder slice
module add_slice #(
    parameter int N = 4
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);

    // Widen by one bit so the carry out falls out of a single addition.
    assign {co, s} = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, ci};

endmodule

// File: rtl/seq_slice_add_ctrl.sv
// rtl/seq_slice_add_ctrl.sv - W-bit adder sequenced over one N-bit slice; SEQ_ADD_SUB_EN enables subtract
module seq_slice_add_ctrl
    import seq_add_pkg::*;
#(
    parameter int W = 16,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         busy
);

    localparam int SLICES = slice_count(W, N);
    localparam int KW     = count_width(SLICES);
    localparam logic [KW-1:0] K_LAST = KW'(SLICES - 1);

    seq_state_t    state_q, state_d;
    logic [KW-1:0] k_q;
    logic          carry_q;
    logic [W-1:0]  a_q, b_q, sum_q;
    logic          cout_q;

    logic [N-1:0]  slice_x, slice_y, slice_s;
    logic          slice_co;
    logic          accept, last_slice, release_result;
    logic [W-1:0]  b_load;
    logic          carry_load;

    assign accept         = (state_q == IDLE) && in_valid;
    assign last_slice     = (state_q == RUN) && (k_q == K_LAST);
    assign release_result = (state_q == DONE) && out_ready;

`ifdef SEQ_ADD_SUB_EN
    // Subtraction is a + ~b + 1; cin is ignored on a subtract.
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_load     = b;
    assign carry_load = cin;
`endif

    // Select the operand bits for the slice currently being computed.
    always_comb begin
        slice_x = a_q[int'(k_q) * N +: N];
        slice_y = b_q[int'(k_q) * N +: N];
    end

    add_slice #(.N(N)) u_slice (
        .x  (slice_x),
        .y  (slice_y),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, walk the slices, hold the result until taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)         state_d = RUN;
            RUN:     if (last_slice)     state_d = DONE;
            DONE:    if (release_result) state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    // Operand capture, per-slice sum/carry update and final carry out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            if (accept) begin
                a_q     <= a;
                b_q     <= b_load;
                carry_q <= carry_load;
                k_q     <= '0;
            end else if (state_q == RUN) begin
                sum_q[int'(k_q) * N +: N] <= slice_s;
                carry_q <= slice_co;
                if (last_slice) begin
                    cout_q <= slice_co;
                    k_q    <= '0;
                end else begin
                    k_q <= k_q + 1'b1;
                end
            end
        end
    end

    // Handshake flags follow the state; in_ready stays low while reset is asserted.
    assign in_ready  = (state_q == IDLE) && rst_n;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_seq_slice_add_ctrl.sv
// tb/tb_seq_slice_add_ctrl.sv - randomized self-checking bench for seq_slice_add_ctrl (SEQ_ADD_SUB_EN optional)
module tb_seq_slice_add_ctrl;

    localparam int W = 16;
    localparam int N = 4;
    localparam int SLICES = W / N;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int checks = 0;
    int errors = 0;

    seq_slice_add_ctrl #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the full width, modulo 2^W with carry in bit W.
    function automatic logic [W:0] ref_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic ci, input logic s);
        logic [W:0] r;
        r = {1'b0, x} + {1'b0, y} + (W + 1)'(ci);
`ifdef SEQ_ADD_SUB_EN
        if (s) r = {1'b0, x} + {1'b0, ~y} + (W + 1)'(1);
`endif
        return r;
    endfunction

    // Issue one operation, check latency, result, hold behaviour and release.
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                          input logic xs, input int hold, input string tag);
        logic [W:0] exp;
        int lat;
        exp = ref_result(xa, xb, xc, xs);
        a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
        check_eq({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        check_eq({tag, ".busy"}, 32'(busy), 32'd1);
        check_eq({tag, ".no_ready_run"}, 32'(in_ready), 32'd0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, ".latency"}, 32'(lat), 32'(SLICES + 1));
        check_eq({tag, ".sum"}, 32'(sum), 32'(exp[W-1:0]));
        check_eq({tag, ".cout"}, 32'(cout), 32'(exp[W]));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check_eq({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            check_eq({tag, ".hold_sum"}, 32'({cout, sum}), 32'(exp));
            check_eq({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({tag, ".released"}, 32'(out_valid), 32'd0);
        check_eq({tag, ".idle_ready"}, 32'(in_ready), 32'd1);
        check_eq({tag, ".idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #2;
        check_eq("rst.sum", 32'(sum), 32'd0);
        check_eq("rst.cout", 32'(cout), 32'd0);
        check_eq("rst.out_valid", 32'(out_valid), 32'd0);
        check_eq("rst.busy", 32'(busy), 32'd0);
        #15 rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rst.in_ready", 32'(in_ready), 32'd1);

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, "t1");
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, "t2");
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0, "t3");
        run_op(16'hA5C3, 16'h5A3C, 1'b1, 1'b0, 3, "t4");

        // Abort during RUN after two slices.
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("t5.sum", 32'(sum), 32'd0);
        check_eq("t5.cout", 32'(cout), 32'd0);
        check_eq("t5.out_valid", 32'(out_valid), 32'd0);
        check_eq("t5.busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("t5.in_ready", 32'(in_ready), 32'd1);
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, "t5b");

`ifdef SEQ_ADD_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, "t6a");
        run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 1, "t6b");
`endif

        for (int i = 0; i < 24; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
